// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-ported accelerator SRAM between NUM_REQ requesters.
// One access is accepted per cycle by round-robin. A requester can lock the
// port for multi-beat bursts. Read data comes back with a per-requester valid
// tag RD_LAT+1 cycles after the grant.
module sram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       sram_write_enable,
    output logic [ADDR_W-1:0]          sram_write_addresss,
    output logic [DATA_W-1:0]          sram_write_data,
    output logic [ADDR_W-1:0]          sram_read_address,
    input  logic [DATA_W-1:0]          sram_read_data,
    output logic                       arb_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ARB_OPEN = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  owner_reg;
    logic [IDX_W-1:0]  last_grant_reg;

    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [ADDR_W-1:0] raddr_reg;
    logic              busy_reg;

    // Read tags: stage 0 is loaded together with the read address, the last
    // stage lines up with the cycle the SRAM presents the data.
    logic [RD_LAT:0]   tag_valid_reg;
    logic [IDX_W-1:0]  tag_idx_reg [RD_LAT+1];

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    logic              open_found;
    logic [IDX_W-1:0]  open_idx;
    int                cand;
    logic [IDX_W-1:0]  cand_idx;

    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic              wr_fire;
    logic              rd_fire;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search: first valid requester after the last one granted.
    always_comb begin
        open_found = 1'b0;
        open_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(last_grant_reg) + 1 + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!open_found && req_valid[cand_idx]) begin
                open_found = 1'b1;
                open_idx   = cand_idx;
            end
        end
    end

    // Grant selection: while locked only the owner may be served.
    always_comb begin
        if (state_reg == ARB_LOCK) begin
            grant_any = req_valid[owner_reg];
            grant_idx = owner_reg;
        end else begin
            grant_any = open_found;
            grant_idx = open_idx;
        end
        wr_fire   = grant_any &  req_we[grant_idx];
        rd_fire   = grant_any & ~req_we[grant_idx];
        // Nothing is accepted while reset is held, so the grant is masked too.
        req_grant = (grant_any && reset_b) ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Arbitration FSM: lock state, lock owner and round-robin pointer.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg      <= ARB_OPEN;
            owner_reg      <= '0;
            last_grant_reg <= LAST_IDX;
        end else begin
            if (grant_any) begin
                last_grant_reg <= grant_idx;
            end
            case (state_reg)
                ARB_OPEN: begin
                    // A lock request only counts on a granted beat.
                    if (grant_any && req_lock[grant_idx]) begin
                        state_reg <= ARB_LOCK;
                        owner_reg <= grant_idx;
                    end
                end
                ARB_LOCK: begin
                    // Released by a final beat (lock low) or by the owner
                    // going idle with its lock low; both reduce to lock low.
                    if (!req_lock[owner_reg]) begin
                        state_reg <= ARB_OPEN;
                    end
                end
                default: state_reg <= ARB_OPEN;
            endcase
        end
    end

    // SRAM port registers: write strobe pulses, addresses and data hold.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
            raddr_reg <= '0;
        end else begin
            we_reg <= wr_fire;
            if (wr_fire) begin
                waddr_reg <= addr_arr[grant_idx];
                wdata_reg <= wdata_arr[grant_idx];
            end
            if (rd_fire) begin
                raddr_reg <= addr_arr[grant_idx];
            end
        end
    end

    // Read tag pipeline, shifting every cycle so responses stay in grant order.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tag_valid_reg <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_idx_reg[s] <= '0;
            end
        end else begin
            tag_valid_reg  <= {tag_valid_reg[RD_LAT-1:0], rd_fire};
            tag_idx_reg[0] <= grant_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_idx_reg[s] <= tag_idx_reg[s-1];
            end
        end
    end

    // Busy flag: something pending, a read in flight, or the port locked.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= (|req_valid) | (|tag_valid_reg) | (state_reg == ARB_LOCK);
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_valid_reg[RD_LAT] &&
                                   (tag_idx_reg[RD_LAT] == IDX_W'(gi));
        end
    endgenerate

    assign rsp_data            = sram_read_data;
    assign sram_write_enable   = we_reg;
    assign sram_write_addresss = waddr_reg;
    assign sram_write_data     = wdata_reg;
    assign sram_read_address   = raddr_reg;
    assign arb_busy            = busy_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int N   = 3;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              reset_b = 1'b1;
    logic [N-1:0]      req_valid = '0, req_we = '0, req_lock = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      req_grant, rsp_valid;
    logic [DW-1:0]     rsp_data, sram_write_data, sram_read_data;
    logic              sram_write_enable, arb_busy;
    logic [AW-1:0]     sram_write_addresss, sram_read_address;

    // Second instance built with RD_LAT=3 for the latency check.
    logic [N-1:0]      valid3 = '0, we3 = '0, lock3 = '0;
    logic [N*AW-1:0]   addr3 = '0;
    logic [N*DW-1:0]   wdata3 = '0;
    logic [N-1:0]      grant3, rsp_valid3;
    logic [DW-1:0]     rsp_data3, wd3;
    logic [DW-1:0]     rdd3 = 16'h1234;
    logic              we3o, busy3;
    logic [AW-1:0]     wa3, ra3;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .reset_b(reset_b),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_write_enable(sram_write_enable), .sram_write_addresss(sram_write_addresss),
        .sram_write_data(sram_write_data), .sram_read_address(sram_read_address),
        .sram_read_data(sram_read_data), .arb_busy(arb_busy)
    );

    sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_lat3 (
        .clk(clk), .reset_b(reset_b),
        .req_valid(valid3), .req_we(we3), .req_lock(lock3),
        .req_addr(addr3), .req_wdata(wdata3),
        .req_grant(grant3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .sram_write_enable(we3o), .sram_write_addresss(wa3),
        .sram_write_data(wd3), .sram_read_address(ra3),
        .sram_read_data(rdd3), .arb_busy(busy3)
    );

    // SRAM behavioural model: writes land one edge after the strobe register,
    // read data appears LAT cycles after the read address register updates.
    logic [DW-1:0] sram_mem [4096];
    logic [DW-1:0] rd_pipe  [LAT];
    always @(posedge clk) begin
        if (sram_write_enable) sram_mem[sram_write_addresss] <= sram_write_data;
        rd_pipe[0] <= sram_mem[sram_read_address];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_read_data = rd_pipe[LAT-1];

    // Reference model state.
    typedef struct { logic we; logic lock; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
    typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;

    txn_t          tq [N][64];
    int            head [N];
    int            tail [N];
    rsp_t          rsp_q [$];
    logic [DW-1:0] ref_mem [4096];
    int            cyc;
    bit            m_locked;
    int            m_owner, m_last;
    logic          exp_we, exp_busy;
    logic [AW-1:0] exp_waddr, exp_raddr;
    logic [DW-1:0] exp_wdata;
    bit            idle_lock_en;
    int            n_checks, n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
    endtask

    task automatic enq(input int r, input logic we, input logic lock,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        tq[r][tail[r] % 64] = '{we: we, lock: lock, addr: a, wdata: d};
        tail[r]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_last = N - 1;
        exp_we = 1'b0; exp_busy = 1'b0;
        exp_waddr = '0; exp_wdata = '0; exp_raddr = '0;
        rsp_q.delete();
    endtask

    // Present each requester's oldest queued transaction.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                txn_t t = tq[i][head[i] % 64];
                req_valid[i] = 1'b1;
                req_we[i]    = t.we;
                req_lock[i]  = t.lock;
                req_addr[i*AW +: AW]  = t.addr;
                req_wdata[i*DW +: DW] = t.wdata;
            end else begin
                req_valid[i] = 1'b0;
                req_we[i]    = 1'b0;
                req_lock[i]  = idle_lock_en ? ($urandom_range(3) == 0) : 1'b0;
            end
        end
    endtask

    // Who should be granted: owner only while locked, else round-robin.
    function automatic int model_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int c = (m_last + 1 + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check everything, advance the model.
    task automatic cycle(input int want_g);
        int   g;
        bit   inflight;
        txn_t t;
        drive();
        #1;
        g = model_grant();
        chk("grant", 32'(req_grant), (g >= 0) ? (1 << g) : 0);
        if (want_g >= 0) chk("grant_order", 32'(req_grant), 1 << want_g);
        chk("wr_en", 32'(sram_write_enable), 32'(exp_we));
        chk("wr_addr", 32'(sram_write_addresss), 32'(exp_waddr));
        chk("wr_data", 32'(sram_write_data), 32'(exp_wdata));
        chk("rd_addr", 32'(sram_read_address), 32'(exp_raddr));
        chk("busy", 32'(arb_busy), 32'(exp_busy));
        inflight = (rsp_q.size() != 0);
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 1 << rsp_q[0].idx);
            chk("rsp_data", 32'(rsp_data), 32'(rsp_q[0].data));
            void'(rsp_q.pop_front());
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 0);
        end
        exp_busy = (req_valid != '0) || inflight || m_locked;
        exp_we   = 1'b0;
        if (g >= 0) begin
            t = tq[g][head[g] % 64];
            head[g]++;
            if (t.we) begin
                exp_we = 1'b1; exp_waddr = t.addr; exp_wdata = t.wdata;
                ref_mem[t.addr] = t.wdata;
            end else begin
                exp_raddr = t.addr;
                rsp_q.push_back('{due: cyc + 1 + LAT, idx: g, data: ref_mem[t.addr]});
            end
            if (!m_locked && t.lock) begin
                m_locked = 1'b1; m_owner = g;
            end
            m_last = g;
        end
        // Lock ends once the owner's lock bit is low (last beat or owner idle).
        if (m_locked && !req_lock[m_owner]) m_locked = 1'b0;
        @(posedge clk); cyc++; @(negedge clk);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) cycle(-1);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            sram_mem[a] <= 16'(a + 16'h0100);
            ref_mem[a]   = 16'(a + 16'h0100);
        end
        model_reset();
        cyc = 0; n_checks = 0; n_pass = 0; idle_lock_en = 1'b0;

        // Reset state.
        #2 reset_b = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_grant", 32'(req_grant), 0);
        chk("rst_rsp", 32'(rsp_valid), 0);
        chk("rst_we", 32'(sram_write_enable), 0);
        chk("rst_raddr", 32'(sram_read_address), 0);
        chk("rst_busy", 32'(arb_busy), 0);
        @(negedge clk); reset_b = 1'b1;

        // Three readers, round-robin 0,1,2,0,1,2.
        for (int r = 0; r < N; r++) begin
            enq(r, 1'b0, 1'b0, 12'(16 * (r + 1)), '0);
            enq(r, 1'b0, 1'b0, 12'(16 * (r + 1)), '0);
        end
        for (int k = 0; k < 6; k++) cycle(k % N);
        flush(4);

        // Write by 1, then read-back by 0 the following cycle.
        enq(1, 1'b1, 1'b0, 12'h005, 16'hBEEF);
        cycle(1);
        enq(0, 1'b0, 1'b0, 12'h005, '0);
        cycle(0);
        flush(4);

        // Locked 4-beat burst from 2 while 0 and 1 keep asking.
        enq(2, 1'b0, 1'b1, 12'h200, '0);
        enq(2, 1'b0, 1'b1, 12'h201, '0);
        enq(2, 1'b0, 1'b1, 12'h202, '0);
        enq(2, 1'b0, 1'b0, 12'h203, '0);
        cycle(2);
        for (int k = 0; k < 2; k++) begin
            enq(0, 1'b0, 1'b0, 12'h300, '0);
            enq(1, 1'b0, 1'b0, 12'h301, '0);
        end
        cycle(2); cycle(2); cycle(2);
        cycle(0); cycle(1); cycle(0); cycle(1);
        flush(4);

        // Single requester streaming 5 reads.
        for (int k = 0; k < 5; k++) enq(1, 1'b0, 1'b0, 12'(12'h040 + k), '0);
        for (int k = 0; k < 5; k++) cycle(1);
        flush(4);

        // Reset in the middle of a locked 2-read burst.
        enq(0, 1'b0, 1'b1, 12'h050, '0);
        enq(0, 1'b0, 1'b0, 12'h051, '0);
        cycle(0);
        enq(1, 1'b0, 1'b0, 12'h052, '0);
        drive();
        reset_b = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(req_grant), 0);
        chk("mid_rst_rsp", 32'(rsp_valid), 0);
        chk("mid_rst_waddr", 32'(sram_write_addresss), 0);
        chk("mid_rst_wdata", 32'(sram_write_data), 0);
        chk("mid_rst_raddr", 32'(sram_read_address), 0);
        chk("mid_rst_busy", 32'(arb_busy), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); cyc++; @(negedge clk); #1;
            chk("in_rst_rsp", 32'(rsp_valid), 0);
            chk("in_rst_we", 32'(sram_write_enable), 0);
        end
        @(negedge clk); cyc++;
        reset_b = 1'b1;
        model_reset();
        cycle(0); cycle(1);
        flush(4);

        // Randomized traffic with locks and idle lock bits.
        idle_lock_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < N; r++) begin
                if (head[r] == tail[r] && $urandom_range(1) == 1)
                    enq(r, 1'($urandom_range(1)), ($urandom_range(4) == 0),
                        12'($urandom_range(15)), 16'($urandom));
            end
            cycle(-1);
        end
        idle_lock_en = 1'b0;
        for (int k = 0; k < 200 && !all_empty(); k++) cycle(-1);
        if (!all_empty()) begin
            n_checks++;
            $error("FAIL drain_timeout: observed queued requests expected none");
        end
        flush(5);

        // RD_LAT=3 instance: single read, response exactly 4 cycles later.
        valid3 = 3'b001; addr3[AW-1:0] = 12'h0AB;
        #1;
        chk("lat3_grant", 32'(grant3), 1);
        @(posedge clk); @(negedge clk);
        valid3 = '0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk("lat3_rsp", 32'(rsp_valid3), (k == 4) ? 1 : 0);
            if (k == 1) chk("lat3_raddr", 32'(ra3), 32'h0AB);
            if (k == 4) chk("lat3_data", 32'(rsp_data3), 32'h1234);
            @(posedge clk); @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter sharing one single-ported accelerator SRAM (input, weights, scratchpad or output) between up to NUM_REQ requesters, e.g. the convolution/max-pool engine, the weight loader and the result drain. It issues one read or write per cycle to the SRAM, returns read data with a per-requester valid tag after a fixed latency, and supports locked bursts so a requester can own the port for multi-beat accesses such as a 4-row sub-matrix fetch.

## Interface
- NUM_REQ, 3, number of requesters (2–8)
- ADDR_W, 12, SRAM address width
- DATA_W, 16, SRAM data width
- RD_LAT, 1, cycles from sram_read_address update to valid sram_read_data (1–3)

- clk  in  1  single clock, rising edge
- reset_b  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep the port after this beat
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_grant  out  NUM_REQ  combinational one-hot accept for this cycle
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_data  out  DATA_W  read data, shared by all requesters
- sram_write_enable  out  1  registered write strobe
- sram_write_addresss  out  ADDR_W  registered write address
- sram_write_data  out  DATA_W  registered write data
- sram_read_address  out  ADDR_W  registered read address
- sram_read_data  in  DATA_W  SRAM read data
- arb_busy  out  1  any request pending, any read in flight, or locked

## Operation
- The arbiter has two states:
  - ARB_OPEN: round-robin. The search starts at last_grant+1 mod NUM_REQ, and the first requester with req_valid set is granted.
  - ARB_LOCK: only the owner can be granted. All other requesters wait, with grant 0.
- Transitions:
  - OPEN→LOCK when the granted beat has req_lock=1; the owner becomes the granted requester.
  - LOCK→OPEN when the owner's granted beat has req_lock=0, or in any cycle where owner req_valid=0 and req_lock[owner]=0.
- last_grant updates on every grant.
- At most one bit of req_grant is set per cycle. A transaction is accepted exactly in a cycle where req_grant[i]=1. Requesters hold valid, we, addr and wdata stable until granted.
- Granted write: at the next edge, load sram_write_enable=1, sram_write_addresss and sram_write_data. With no write grant that cycle, sram_write_enable=0, and address/data hold their values.
- Granted read: at the next edge, load sram_read_address. The owner index enters a tag pipeline of RD_LAT+1 stages. sram_read_address holds when there is no read grant.
- Response: rsp_valid is one-hot with the index from the tag pipeline output. rsp_data = sram_read_data, passed through combinationally. Responses return in grant order, with no reordering.
- Back-to-back reads from different requesters are legal every cycle, and each returns on its own tag.
- Arithmetic: the round-robin pointer and lock owner are clog2(NUM_REQ) bits. The pointer wraps NUM_REQ-1 → 0.
- Reset values:
  - all registered outputs 0; rsp_valid 0
  - state ARB_OPEN
  - last_grant = NUM_REQ-1, so requester 0 has first priority
  - tag pipeline empty
- reset_b asserted mid-burst: the lock is dropped and in-flight reads are discarded (no rsp_valid). No write strobe is issued after reset.
- Edge cases:
  - req_lock set while req_valid=0 in OPEN: ignored.
  - Owner requests in LOCK: granted every cycle regardless of the other requesters.

## Timing
- Cycle t: grant (combinational from req_valid, state and pointer).
- Edge t→t+1: SRAM port registers load.
- Writes land in the SRAM at the t+1 edge.
- Reads: rsp_valid/rsp_data are valid in cycle t+1+RD_LAT (t+2 at default).
- Throughput: one access per cycle.
- Lock fairness: the maximum wait for a non-owner is unbounded while the owner holds req_lock. Otherwise it is ≤ NUM_REQ-1 grants.
- arb_busy is registered; it reflects the previous cycle's pending, in-flight and lock status.

## Test plan
- Reset, then req_valid=3'b111, all reads, addrs 0x010/0x020/0x030, SRAM model returning addr+0x100 → grants go 0,1,2,0,…; requester 0 gets rsp_valid with 0x110 two cycles after its grant, then 1 with 0x120, then 2 with 0x130.
- Requester 1 writes 0xBEEF to 0x005 while requester 0 reads 0x005 the next cycle → sram_write_enable pulses one cycle with addr 0x005 and data 0xBEEF; the following read returns 0xBEEF.
- Requester 2 sends a locked burst of 4 reads (req_lock=1,1,1,0) while 0 and 1 keep requesting → four consecutive grants to 2, then requester 0 is granted, then 1.
- Only requester 1 requests, for 5 cycles → granted every cycle; rsp_valid[1] high 5 consecutive cycles, starting 2 cycles after the first grant.
- Assert reset_b low during a 2-read burst → all outputs go to 0 immediately; no rsp_valid after release; the first grant after release goes to requester 0.
- RD_LAT=3 build, a single read by requester 0 → rsp_valid[0] arrives exactly 4 cycles after the grant, one cycle wide.
